// File: rtl/nn_mm_scheduler.sv
// Layer-pass sequencer for the shared matrix-multiply engine: streams each
// step's packed words from the buffer RAM into the engine, strobes it, waits for ready.
module nn_mm_scheduler #(
  parameter int WORDS_PER_STEP = 13,
  parameter int ADDR_W         = 10,
  parameter int CNT_W          = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [CNT_W-1:0]  i_n_steps,
  input  logic [ADDR_W-1:0] i_base_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [31:0]       i_rd_data,
  output logic              o_load_vld,
  output logic [31:0]       o_load_data,
  output logic              o_mm_rst,
  output logic              o_mm_next,
  input  logic              i_mm_rdy,
  output logic [CNT_W-1:0]  o_step_cnt
);

  localparam int WC_W = $clog2(WORDS_PER_STEP + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_ISSUE = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]        r_state;
  logic [2:0]        w_nxt;
  logic [WC_W-1:0]   r_word_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_n_steps;
  logic [CNT_W-1:0]  r_step_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_en;
  logic              r_load_vld;
  logic              r_mm_rst;
  logic              r_mm_next;

  logic              w_start_ok;
  logic              w_zero_steps;
  logic              w_last_word;
  logic              w_step_done;
  logic [CNT_W-1:0]  w_step_inc;

  assign w_start_ok   = (r_state == S_IDLE) && i_start && !i_abort;
  assign w_zero_steps = (i_n_steps == '0);
  assign w_last_word  = (r_word_cnt == WC_W'(WORDS_PER_STEP - 1));
  assign w_step_done  = (r_state == S_WAIT) && i_mm_rdy;
  assign w_step_inc   = r_step_cnt + CNT_W'(1);

  // Abort dominates; in IDLE it simply keeps the FSM where it is.
  always_comb begin
    w_nxt = r_state;
    if (i_abort) begin
      w_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (i_start) w_nxt = w_zero_steps ? S_DONE : S_CLR;
        S_CLR:   w_nxt = S_FETCH;
        S_FETCH: if (w_last_word) w_nxt = S_DRAIN;
        S_DRAIN: w_nxt = S_ISSUE;
        S_ISSUE: w_nxt = S_WAIT;
        S_WAIT:  if (i_mm_rdy) w_nxt = (w_step_inc == r_n_steps) ? S_DONE : S_FETCH;
        S_DONE:  w_nxt = S_IDLE;
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_word_cnt <= '0;
      r_addr     <= '0;
      r_n_steps  <= '0;
      r_step_cnt <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_start_ok) begin
        r_step_cnt <= '0;
        if (!w_zero_steps) begin
          r_n_steps <= i_n_steps;
          r_addr    <= i_base_addr;
        end
      end
      // Address keeps running across steps so step k starts at base + k*WORDS_PER_STEP.
      if (r_state == S_FETCH && !i_abort) begin
        r_addr     <= r_addr + ADDR_W'(1);
        r_word_cnt <= r_word_cnt + WC_W'(1);
      end
      if (r_state == S_CLR || r_state == S_ISSUE) r_word_cnt <= '0;
      if (w_step_done && !i_abort) r_step_cnt <= w_step_inc;
    end
  end

  // Strobes are registered from the next state so every output is glitch-free.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_load_vld <= 1'b0;
      r_mm_rst   <= 1'b0;
      r_mm_next  <= 1'b0;
    end else begin
      r_busy     <= (w_nxt != S_IDLE);
      r_done     <= (w_nxt == S_DONE);
      r_rd_en    <= (w_nxt == S_FETCH);
      r_load_vld <= r_rd_en && !i_abort;
      r_mm_rst   <= (w_nxt == S_CLR) || (i_abort && r_state != S_IDLE);
      r_mm_next  <= (w_nxt == S_ISSUE);
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_rd_en     = r_rd_en;
  assign o_rd_addr   = r_addr;
  assign o_load_vld  = r_load_vld;
  assign o_load_data = r_load_vld ? i_rd_data : 32'd0;
  assign o_mm_rst    = r_mm_rst;
  assign o_mm_next   = r_mm_next;
  assign o_step_cnt  = r_step_cnt;

endmodule
